// File: rtl/ad9833_sweep_ctrl.sv
// ----------------------------------------------------------------------------
// ad9833_sweep_ctrl
//
// Stepped frequency sweep sequencer sitting in front of the AD9833 serial
// driver. Each write is one driver transaction carrying a control word and the
// two FREQ0 halves. The sequencer raises go, waits for the driver ack, waits
// for send_complete, then dwells DWELL_CLKS clocks before issuing the next
// write at cur_ftw + ftw_step. In total it issues step_count + 1 writes.
//
// Parameters
//   DWELL_CLKS       clocks spent at each frequency (1..65535)
//
// Ports
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   start            begin a sweep (honoured in IDLE only)
//   abort            level; end the sweep at the next safe boundary
//   ftw_start        first tuning word, captured on start
//   ftw_step         per-step increment, captured on start
//   step_count       number of increments, captured on start
//   go               transaction request to the driver
//   control          control word (B28 set)
//   adreg0           FREQ0 LSB word {01, ftw[13:0]}
//   adreg1           FREQ0 MSB word {01, ftw[27:14]}
//   good_to_reset_go driver ack (level)
//   send_complete    driver end-of-transaction pulse
//   busy             sweep in progress
//   done             one-cycle pulse at sweep end
//   aborted          sweep ended by abort (valid from done to next start)
//   cur_ftw          tuning word of the current/last write
// ----------------------------------------------------------------------------
module ad9833_sweep_ctrl #(
    parameter int DWELL_CLKS = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [27:0] ftw_start,
    input  logic [27:0] ftw_step,
    input  logic [15:0] step_count,
    output logic        go,
    output logic [15:0] control,
    output logic [15:0] adreg0,
    output logic [15:0] adreg1,
    input  logic        good_to_reset_go,
    input  logic        send_complete,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [27:0] cur_ftw
);

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_CMPL,
        DWELL
    } state_t;

    // B28 = 1: both FREQ0 halves are written as consecutive words.
    localparam logic [15:0] CTRL_WORD  = 16'h2000;
    // The dwell counter runs from DWELL_CLKS-1 down to 0, so the write is
    // relaunched on the DWELL_CLKS-th edge after send_complete.
    localparam logic [15:0] DWELL_LOAD = 16'(DWELL_CLKS - 1);

    state_t      state_reg, state_next;
    logic [15:0] remaining_reg, remaining_next;
    logic [15:0] dwell_cnt_reg, dwell_cnt_next;
    logic [27:0] step_reg, step_next;
    logic        abort_pending_reg, abort_pending_next;

    logic        go_reg, go_next;
    logic [15:0] control_reg, control_next;
    logic [15:0] adreg0_reg, adreg0_next;
    logic [15:0] adreg1_reg, adreg1_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        aborted_reg, aborted_next;
    logic [27:0] cur_ftw_reg, cur_ftw_next;

    // 28-bit add; the carry out is intentionally dropped so the sweep wraps.
    logic [27:0] ftw_stepped;
    assign ftw_stepped = cur_ftw_reg + step_reg;

    function automatic logic [15:0] lsb_word(input logic [27:0] f);
        return {2'b01, f[13:0]};
    endfunction

    function automatic logic [15:0] msb_word(input logic [27:0] f);
        return {2'b01, f[27:14]};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg         <= IDLE;
            remaining_reg     <= '0;
            dwell_cnt_reg     <= '0;
            step_reg          <= '0;
            abort_pending_reg <= 1'b0;
            go_reg            <= 1'b0;
            control_reg       <= '0;
            adreg0_reg        <= '0;
            adreg1_reg        <= '0;
            busy_reg          <= 1'b0;
            done_reg          <= 1'b0;
            aborted_reg       <= 1'b0;
            cur_ftw_reg       <= '0;
        end else begin
            state_reg         <= state_next;
            remaining_reg     <= remaining_next;
            dwell_cnt_reg     <= dwell_cnt_next;
            step_reg          <= step_next;
            abort_pending_reg <= abort_pending_next;
            go_reg            <= go_next;
            control_reg       <= control_next;
            adreg0_reg        <= adreg0_next;
            adreg1_reg        <= adreg1_next;
            busy_reg          <= busy_next;
            done_reg          <= done_next;
            aborted_reg       <= aborted_next;
            cur_ftw_reg       <= cur_ftw_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        remaining_next     = remaining_reg;
        dwell_cnt_next     = dwell_cnt_reg;
        step_next          = step_reg;
        abort_pending_next = abort_pending_reg;
        go_next            = go_reg;
        control_next       = control_reg;
        adreg0_next        = adreg0_reg;
        adreg1_next        = adreg1_reg;
        busy_next          = busy_reg;
        done_next          = 1'b0;
        aborted_next       = aborted_reg;
        cur_ftw_next       = cur_ftw_reg;

        case (state_reg)
            IDLE: begin
                abort_pending_next = 1'b0;
                if (start) begin
                    cur_ftw_next   = ftw_start;
                    step_next      = ftw_step;
                    remaining_next = step_count;
                    control_next   = CTRL_WORD;
                    adreg0_next    = lsb_word(ftw_start);
                    adreg1_next    = msb_word(ftw_start);
                    go_next        = 1'b1;
                    busy_next      = 1'b1;
                    aborted_next   = 1'b0;
                    state_next     = LAUNCH;
                end
            end

            LAUNCH: begin
                if (abort) begin
                    abort_pending_next = 1'b1;
                end
                if (good_to_reset_go) begin
                    go_next    = 1'b0;
                    state_next = WAIT_CMPL;
                end
            end

            WAIT_CMPL: begin
                if (send_complete) begin
                    // An abort arriving on the completion edge counts as pending.
                    if ((remaining_reg == 16'd0) || abort_pending_reg || abort) begin
                        done_next          = 1'b1;
                        busy_next          = 1'b0;
                        aborted_next       = abort_pending_reg | abort;
                        abort_pending_next = 1'b0;
                        state_next         = IDLE;
                    end else begin
                        remaining_next = remaining_reg - 16'd1;
                        dwell_cnt_next = DWELL_LOAD;
                        state_next     = DWELL;
                    end
                end else if (abort) begin
                    abort_pending_next = 1'b1;
                end
            end

            DWELL: begin
                // Nothing is in flight here, so abort can end the sweep at once.
                if (abort) begin
                    done_next          = 1'b1;
                    busy_next          = 1'b0;
                    aborted_next       = 1'b1;
                    abort_pending_next = 1'b0;
                    state_next         = IDLE;
                end else if (dwell_cnt_reg == 16'd0) begin
                    cur_ftw_next = ftw_stepped;
                    control_next = CTRL_WORD;
                    adreg0_next  = lsb_word(ftw_stepped);
                    adreg1_next  = msb_word(ftw_stepped);
                    go_next      = 1'b1;
                    state_next   = LAUNCH;
                end else begin
                    dwell_cnt_next = dwell_cnt_reg - 16'd1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign go      = go_reg;
    assign control = control_reg;
    assign adreg0  = adreg0_reg;
    assign adreg1  = adreg1_reg;
    assign busy    = busy_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;
    assign cur_ftw = cur_ftw_reg;

endmodule

// File: doc/ad9833_sweep_ctrl.md
# ad9833_sweep_ctrl

Upstream sequencer for the AD9833 serial driver. It turns a start frequency tuning word (FTW), a step and a step count into a series of driver transactions. Each transaction consists of a control word, a FREQ0 LSB word and a FREQ0 MSB word, and the sequencer handles the driver's go/ack/complete handshake for each one. Between writes it dwells for a programmable number of clocks, which gives a stepped frequency sweep (a single write when step_count = 0).

## Interface
- DWELL_CLKS, default 1000: clocks spent at each frequency after send_complete and before the next write; legal range 1..65535.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  sampled in IDLE only; starts a sweep.
- abort  in  1  level; ends the sweep at the next safe boundary.
- ftw_start  in  28  first FTW; sampled on the start edge.
- ftw_step  in  28  increment added per step; sampled on the start edge.
- step_count  in  16  number of increments; total writes = step_count + 1; sampled on the start edge.
- go  out  1  transaction request to the driver.
- control  out  16  control word to the driver.
- adreg0  out  16  FREQ0 LSB word to the driver.
- adreg1  out  16  FREQ0 MSB word to the driver.
- good_to_reset_go  in  1  driver ack; level-sampled, may stay high permanently.
- send_complete  in  1  single-cycle pulse from the driver at transaction end.
- busy  out  1  high from the start edge until done.
- done  out  1  single-cycle pulse when the sweep ends, normally or by abort.
- aborted  out  1  set with done if the sweep ended by abort; cleared on the next start.
- cur_ftw  out  28  FTW of the current or last write.

## Operation
- States: IDLE, LAUNCH, WAIT_CMPL, DWELL.
- Reset values: every output 0, including control, adreg0 and adreg1. Internal counters reset to 0; state resets to IDLE.
- Word encoding:
  - control = 16'h2000 (B28 = 1, FSELECT = 0, RESET = 0).
  - adreg0 = {2'b01, ftw[13:0]}.
  - adreg1 = {2'b01, ftw[27:14]}.
- IDLE, start = 1:
  - Load cur_ftw ← ftw_start and the remaining-step counter ← step_count.
  - Drive the three words, set go = 1, busy = 1, aborted = 0.
  - Next state LAUNCH.
- Any start while busy is ignored.
- LAUNCH: on the first edge with good_to_reset_go = 1, clear go and go to WAIT_CMPL. Because the ack is level-sampled, a permanently high ack gives a 1-cycle go pulse.
- WAIT_CMPL, send_complete = 1:
  - If remaining = 0 or abort is pending: go to IDLE, pulse done, clear busy, set aborted if abort is pending.
  - Otherwise: decrement remaining, load the dwell counter, go to DWELL.
- DWELL:
  - The counter counts DWELL_CLKS cycles.
  - On expiry: cur_ftw ← (cur_ftw + ftw_step) mod 2^28 (28-bit wrap, carry discarded). Drive the new words, set go = 1, go to LAUNCH.
- Abort:
  - In LAUNCH or WAIT_CMPL it sets an abort_pending flag. The transaction in flight always completes, because the SPI transfer is never truncated.
  - In DWELL it ends the sweep immediately: done pulse, aborted = 1, state IDLE, no further write.
  - In IDLE it is ignored. abort_pending clears on entering IDLE.
- control, adreg0 and adreg1 are held stable from go rising until send_complete is sampled.
- rst mid-sweep:
  - All outputs go to their reset values immediately (asynchronous), including go = 0.
  - No done pulse is produced.
  - Whatever the driver has in flight is not tracked.

## Timing
- start sampled at edge k: go, the words and busy are visible after edge k (latency 1).
- Ack at edge a: go is low after edge a.
- send_complete at edge m, not last write: next go rises after edge m + DWELL_CLKS.
- send_complete at edge m, last write: done is high for exactly the cycle after edge m, and busy falls at the same edge.
- send_complete and abort at the same edge count as abort pending: the sweep ends at that edge with aborted = 1.
- send_complete seen outside WAIT_CMPL is ignored.

## Test plan
- Single write:
  - Stimulus: ftw_start = 28'h1234567, step_count = 0.
  - Required: control = 16'h2000, adreg0 = 16'h4567, adreg1 = 16'h448D; exactly one go; done 1 cycle after send_complete; aborted = 0.
- Three-step sweep with wrap:
  - Stimulus: ftw_start = 28'hFFFFFF0, ftw_step = 28'h10, step_count = 2, DWELL_CLKS = 8; bench driver model acks after 2 cycles and completes after 40.
  - Required: cur_ftw sequence FFFFFF0 → 0000000 → 0000010; go re-rises exactly 8 cycles after each send_complete.
- Sticky ack:
  - Stimulus: good_to_reset_go tied high.
  - Required: each go is exactly 1 cycle wide; the sweep still completes with step_count + 1 transactions.
- Abort timing:
  - Abort during WAIT_CMPL: the in-flight transaction finishes; done and aborted rise with send_complete; no further go.
  - Abort during DWELL: done and aborted rise on the next edge; no further go.
- Reset and restart:
  - Stimulus: rst asserted mid-DWELL, then start applied after release.
  - Required: go, busy, done and all words are 0 immediately, and no done pulse appears; the restarted sweep begins cleanly from the new ftw_start.
